// File: rtl/hist_eq_bank_controller.sv
// Bank sequencer for histogram equalisation: rotates NUM_BANKS CDF banks between the build and remap stages.
// All outputs registered; each start drops for one cycle after its done; input stalls while every bank is full.
module hist_eq_bank_controller #(
    parameter int PIXEL_COUNT = 307200,
    parameter int CDF_WIDTH   = 20,
    parameter int NUM_BANKS   = 2,
    parameter int BANK_W      = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 stop,
    output logic                 input_start,
    input  logic                 input_done,
    output logic [BANK_W-1:0]    input_bank,
    output logic                 output_start,
    input  logic                 output_done,
    output logic [BANK_W-1:0]    output_bank,
    input  logic                 cdf_valid,
    input  logic [CDF_WIDTH-1:0] cdf_min,
    output logic [CDF_WIDTH-1:0] cdf_min_out,
    output logic [CDF_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic [15:0]          frames_done,
    output logic                 div_err
);

    localparam int CNT_W = $clog2(NUM_BANKS + 1);
    localparam int DEPTH = 1 << BANK_W;
    localparam logic [CDF_WIDTH-1:0] PIX  = CDF_WIDTH'(PIXEL_COUNT);
    localparam logic [BANK_W-1:0]    LAST = BANK_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0]     NB   = CNT_W'(NUM_BANKS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    logic                 run_mode;
    logic                 accept;
    logic [BANK_W-1:0]    wr_ptr;
    logic [BANK_W-1:0]    rd_ptr;
    logic [DEPTH-1:0]     full;
    logic [CNT_W-1:0]     full_count;
    logic [CDF_WIDTH-1:0] cdf_reg [DEPTH];

    logic in_fire;
    logic out_fire;
    logic stop_now;

    assign in_fire     = input_start & input_done;
    assign out_fire    = output_start & output_done;
    assign stop_now    = stop | ~accept | ~run_mode;
    assign input_bank  = wr_ptr;
    assign output_bank = rd_ptr;

    // Run control: input enable, accept latch and state transitions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            run_mode    <= 1'b0;
            accept      <= 1'b0;
            input_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    input_start <= 1'b0;
                    if (start) begin
                        state       <= RUN;
                        run_mode    <= continuous;
                        accept      <= 1'b1;
                        input_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop || !run_mode)
                        accept <= 1'b0;
                    // No frame in flight (or the last one closing now): hand over to drain.
                    if (stop_now && (!input_start || input_done)) begin
                        state       <= DRAIN;
                        input_start <= 1'b0;
                    end else if (in_fire) begin
                        input_start <= 1'b0;
                    end else if (!input_start) begin
                        input_start <= (full_count < NB);
                    end
                end
                DRAIN: begin
                    input_start <= 1'b0;
                    if (full_count == '0 && !output_start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    input_start <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Bank bookkeeping and output enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            full         <= '0;
            full_count   <= '0;
            output_start <= 1'b0;
            frames_done  <= 16'd0;
        end else begin
            if (in_fire) begin
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= (wr_ptr == LAST) ? '0 : wr_ptr + BANK_W'(1);
            end
            // Input only runs with a free bank, so wr_ptr never equals rd_ptr here.
            if (out_fire) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= (rd_ptr == LAST) ? '0 : rd_ptr + BANK_W'(1);
                frames_done  <= frames_done + 16'd1;
            end
            if (in_fire && !out_fire)
                full_count <= full_count + CNT_W'(1);
            else if (out_fire && !in_fire)
                full_count <= full_count - CNT_W'(1);

            if (state == IDLE)
                output_start <= 1'b0;
            else if (out_fire)
                output_start <= 1'b0;
            else if (!output_start)
                output_start <= full[rd_ptr];
        end
    end

    // CDF capture per bank and remap constants for the bank being read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                cdf_reg[i] <= '0;
            cdf_min_out <= '0;
            divisor     <= PIX;
            div_err     <= 1'b0;
        end else begin
            if (input_start && cdf_valid)
                cdf_reg[wr_ptr] <= cdf_min;

            if (state == IDLE && start)
                div_err <= 1'b0;
            else if (input_start && cdf_valid && cdf_min >= PIX)
                div_err <= 1'b1;

            cdf_min_out <= cdf_reg[rd_ptr];
            if (cdf_reg[rd_ptr] < PIX)
                divisor <= PIX - cdf_reg[rd_ptr];
            else
                divisor <= CDF_WIDTH'(1);
        end
    end

endmodule
